word_unbuffer: RTL

// - Transmit-side counterpart of the PS/2 receive buffer: loads one 32-bit word and

---
 rtl/ps2_pkg.sv | 6 +
 rtl/word_unbuffer.sv | 86 ++++++++
 2 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: constants and FSM state type shared by the PS/2 word buffer and unbuffer.
package ps2_pkg;
  localparam int BYTE_W = 8;
  localparam int Z_W = 3;
  typedef enum logic [1:0] {IDLE, WAIT_TICK, PRESENT, DONE} state_t;
endpackage

// File: rtl/word_unbuffer.sv
// word_unbuffer: splits a word into tick-paced bytes, MSB first, with valid/ack handshake.
// Optional q_par output (odd parity of q) when WORD_UNBUFFER_PARITY_EN is defined.
module word_unbuffer
  import ps2_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     load,
  input  logic [BYTE_W*NBYTES-1:0] din,
  output logic                     busy,
  output logic [BYTE_W-1:0]        q,
  output logic                     q_valid,
  input  logic                     q_ack,
  output logic [Z_W-1:0]           z,
  output logic                     listo
`ifdef WORD_UNBUFFER_PARITY_EN
  ,
  output logic                     q_par
`endif
);
  localparam int W = BYTE_W * NBYTES;
  state_t            r_state;
  logic [W-1:0]      r_sreg;
  logic [BYTE_W-1:0] r_q;
  logic [Z_W-1:0]    r_z;
  logic              r_busy, r_q_valid, r_listo;
  logic [BYTE_W-1:0] w_top;
  logic              w_last;
  assign w_top  = r_sreg[W-1 -: BYTE_W];
  assign w_last = r_z == Z_W'(NBYTES - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sreg    <= '0;
      r_q       <= '0;
      r_z       <= '0;
      r_busy    <= 1'b0;
      r_q_valid <= 1'b0;
      r_listo   <= 1'b0;
    end else begin
      r_listo <= 1'b0;
      case (r_state)
        IDLE: if (load) begin
          r_sreg  <= din;
          r_z     <= '0;
          r_busy  <= 1'b1;
          r_state <= WAIT_TICK;
        end
        WAIT_TICK: if (tick) begin
          r_q       <= w_top;
          r_q_valid <= 1'b1;
          r_state   <= PRESENT;
        end
        // a tick coinciding with the ack is dropped; the next byte needs a fresh tick
        PRESENT: if (q_ack) begin
          r_q_valid <= 1'b0;
          r_sreg    <= r_sreg << BYTE_W;
          r_z       <= r_z + Z_W'(1);
          r_listo   <= w_last;
          r_state   <= w_last ? DONE : WAIT_TICK;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef WORD_UNBUFFER_PARITY_EN
  logic r_q_par;
  always_ff @(posedge clk) begin
    if (reset) r_q_par <= 1'b0;
    else if (r_state == WAIT_TICK && tick) r_q_par <= ~^w_top;
  end
  assign q_par = r_q_par;
`endif
  assign busy    = r_busy;
  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign z       = r_z;
  assign listo   = r_listo;
endmodule
